vx_priority_dispatcher: RTL and testbench

Credit-based 1-to-N stream dispatcher, the fan-out counterpart of the priority arbiter. It accepts one input stream and steers each item to the lowest-index output lane that holds a free credit. Items pass through a single-entry registered output stage. Credits reserve downstream buffer space, and lanes hand them back with `credit_return` pulses. It sits between a shared issue stage and N per-lane consumers, for example warp schedulers feeding per-core queues.

---
 rtl/vx_priority_dispatcher.sv | 150 +++++++++++++++
 tb/tb_vx_priority_dispatcher.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_priority_dispatcher.sv
// vx_priority_dispatcher: credit-based 1-to-N stream dispatcher.
// Each accepted item is steered to the lowest-index lane holding a free credit
// and parked in a single-entry registered output stage until that lane is ready.
// Credits are reserved at accept time and handed back through credit_return.
// Optional feature: define VX_DISPATCH_LOCK_EN to pin dispatch to one lane
// (chosen by the first accept) until an unlock pulse releases it.
module vx_priority_dispatcher #(
    parameter int NUM_LANES     = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int CREDITS       = 2,
    parameter int LOG_NUM_LANES = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    parameter int CREDIT_W      = $clog2(CREDITS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic                     ready_in,
    input  logic                     unlock,
    output logic [NUM_LANES-1:0]     valid_out,
    output logic [DATA_WIDTH-1:0]    data_out,
    input  logic [NUM_LANES-1:0]     ready_out,
    output logic [LOG_NUM_LANES-1:0] lane_index,
    input  logic [NUM_LANES-1:0]     credit_return,
    output logic [NUM_LANES-1:0]     credit_avail
);

    localparam int CW1 = CREDIT_W + 1;

    logic [CREDIT_W-1:0]      credit_q [NUM_LANES];
    logic [CREDIT_W-1:0]      credit_d [NUM_LANES];
    logic [NUM_LANES-1:0]     creditOverflow;

    logic                     full_q;
    logic                     full_d;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [DATA_WIDTH-1:0]    data_d;
    logic [LOG_NUM_LANES-1:0] target_q;
    logic [LOG_NUM_LANES-1:0] target_d;

    logic [LOG_NUM_LANES-1:0] selFree;
    logic [LOG_NUM_LANES-1:0] sel;
    logic                     anyCredit;
    logic                     creditOk;
    logic                     fire;
    logic                     accept;

    // Lane i advertises availability whenever its registered counter is nonzero.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            credit_avail[i] = (credit_q[i] != '0);
        end
    end

    assign anyCredit = |credit_avail;

    // Pick the lowest-index lane with a registered credit; scanning downward lets the lowest win.
    always_comb begin
        selFree = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (credit_q[i] != '0) begin
                selFree = LOG_NUM_LANES'(i);
            end
        end
    end

`ifdef VX_DISPATCH_LOCK_EN
    logic                     locked_q;
    logic [LOG_NUM_LANES-1:0] lockLane_q;

    assign sel      = locked_q ? lockLane_q : selFree;
    assign creditOk = locked_q ? (credit_q[lockLane_q] != '0) : anyCredit;

    // The first accept while unlocked latches its lane; unlock releases it at the next edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            locked_q   <= 1'b0;
            lockLane_q <= '0;
        end else if (unlock) begin
            locked_q   <= 1'b0;
        end else if (accept && !locked_q) begin
            locked_q   <= 1'b1;
            lockLane_q <= sel;
        end
    end
`else
    logic unused_unlock;

    assign unused_unlock = unlock;
    assign sel           = selFree;
    assign creditOk      = anyCredit;
`endif

    assign fire     = full_q && ready_out[target_q];
    assign ready_in = (!full_q || fire) && creditOk;
    assign accept   = valid_in && ready_in;

    // Output stage loads on accept and empties on a fire with no replacement; a held item never re-steers.
    always_comb begin
        full_d   = full_q;
        data_d   = data_q;
        target_d = target_q;
        if (accept) begin
            full_d   = 1'b1;
            data_d   = data_in;
            target_d = sel;
        end else if (fire) begin
            full_d   = 1'b0;
        end
    end

    // Consume on accept, add on return; a return beyond capacity saturates and is flagged.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            logic [CW1-1:0] wide;
            wide = {1'b0, credit_q[i]}
                 - CW1'(accept && (sel == LOG_NUM_LANES'(i)))
                 + CW1'(credit_return[i]);
            creditOverflow[i] = (wide > CW1'(CREDITS));
            credit_d[i]       = creditOverflow[i] ? CREDIT_W'(CREDITS) : wide[CREDIT_W-1:0];
        end
    end

    // All dispatcher state; reset drops any held item and refills every lane.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q   <= 1'b0;
            data_q   <= '0;
            target_q <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                credit_q[i] <= CREDIT_W'(CREDITS);
            end
        end else begin
            full_q   <= full_d;
            data_q   <= data_d;
            target_q <= target_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    assign valid_out  = full_q ? (NUM_LANES'(1) << target_q) : '0;
    assign data_out   = data_q;
    assign lane_index = target_q;

    // Returning more credits than a lane owns is a downstream protocol error.
    creditOverflowCheck: assert property (@(posedge clk) disable iff (!reset) creditOverflow == '0);

endmodule

// File: tb/tb_vx_priority_dispatcher.sv
// tb_vx_priority_dispatcher: directed self-checking bench for vx_priority_dispatcher
// (NUM_LANES=4, DATA_WIDTH=32, CREDITS=2). The lock scenario is built only
// when VX_DISPATCH_LOCK_EN is defined.
module tb_vx_priority_dispatcher;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [31:0] data_in;
    logic        ready_in;
    logic        unlock;
    logic [3:0]  valid_out;
    logic [31:0] data_out;
    logic [3:0]  ready_out;
    logic [1:0]  lane_index;
    logic [3:0]  credit_return;
    logic [3:0]  credit_avail;

    int compared;
    int mismatched;

    vx_priority_dispatcher #(
        .NUM_LANES (4),
        .DATA_WIDTH(32),
        .CREDITS   (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .ready_in     (ready_in),
        .unlock       (unlock),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .ready_out    (ready_out),
        .lane_index   (lane_index),
        .credit_return(credit_return),
        .credit_avail (credit_avail)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge, where inputs change and outputs are sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        valid_in      = 1'b0;
        data_in       = '0;
        unlock        = 1'b0;
        credit_return = '0;
        ready_out     = 4'b1111;
        reset         = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        valid_in      = 1'b0;
        data_in       = '0;
        unlock        = 1'b0;
        credit_return = '0;
        ready_out     = 4'b1111;
        reset         = 1'b0;
        step();
        compared++; if (valid_out !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_valid got %b exp 0000", valid_out); end
        compared++; if (lane_index !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_lane got %0d exp 0", lane_index); end
        compared++; if (data_out !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_data got %h exp 0", data_out); end
        compared++; if (ready_in !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready got %b exp 1", ready_in); end
        compared++; if (credit_avail !== 4'b1111) begin mismatched++; $display("[TB] FAIL reset_avail got %b exp 1111", credit_avail); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic_dispatch();
        logic [31:0] expData [3];
        logic [3:0]  expValid [3];
        logic [1:0]  expLane [3];
        expData  = '{32'hA0, 32'hA1, 32'hA2};
        expValid = '{4'b0001, 4'b0001, 4'b0010};
        expLane  = '{2'd0, 2'd0, 2'd1};
        ready_out = 4'b1111;
        valid_in  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_in = expData[k];
            compared++; if (ready_in !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_ready%0d got %b exp 1", k, ready_in); end
            step();
            compared++; if (valid_out !== expValid[k]) begin mismatched++; $display("[TB] FAIL basic_valid%0d got %b exp %b", k, valid_out, expValid[k]); end
            compared++; if (data_out !== expData[k]) begin mismatched++; $display("[TB] FAIL basic_data%0d got %h exp %h", k, data_out, expData[k]); end
            compared++; if (lane_index !== expLane[k]) begin mismatched++; $display("[TB] FAIL basic_lane%0d got %0d exp %0d", k, lane_index, expLane[k]); end
        end
        valid_in = 1'b0;
        compared++; if (credit_avail !== 4'b1110) begin mismatched++; $display("[TB] FAIL basic_avail got %b exp 1110", credit_avail); end
        step();
        compared++; if (valid_out !== 4'b0000) begin mismatched++; $display("[TB] FAIL basic_drain got %b exp 0000", valid_out); end
        compared++; if (lane_index !== 2'd1) begin mismatched++; $display("[TB] FAIL basic_lane_hold got %0d exp 1", lane_index); end
        compared++; if (data_out !== 32'hA2) begin mismatched++; $display("[TB] FAIL basic_data_hold got %h exp a2", data_out); end
    endtask

    // Continues from the basic dispatch state: counters {2,2,1,0} (lane 3..0).
    task automatic test_credit_exhaustion();
        logic [1:0] expLane [5];
        expLane  = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        valid_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            data_in = 32'hB0 + k;
            step();
            compared++; if (lane_index !== expLane[k]) begin mismatched++; $display("[TB] FAIL exhaust_lane%0d got %0d exp %0d", k, lane_index, expLane[k]); end
        end
        data_in = 32'hC0;
        compared++; if (ready_in !== 1'b0) begin mismatched++; $display("[TB] FAIL exhaust_ready_full got %b exp 0", ready_in); end
        compared++; if (credit_avail !== 4'b0000) begin mismatched++; $display("[TB] FAIL exhaust_avail got %b exp 0000", credit_avail); end
        step();
        compared++; if (valid_out !== 4'b0000) begin mismatched++; $display("[TB] FAIL exhaust_empty got %b exp 0000", valid_out); end
        compared++; if (ready_in !== 1'b0) begin mismatched++; $display("[TB] FAIL exhaust_ready_empty got %b exp 0", ready_in); end
        credit_return = 4'b0100;
        compared++; if (ready_in !== 1'b0) begin mismatched++; $display("[TB] FAIL exhaust_ready_same_cycle got %b exp 0", ready_in); end
        step();
        credit_return = 4'b0000;
        compared++; if (ready_in !== 1'b1) begin mismatched++; $display("[TB] FAIL exhaust_ready_after_return got %b exp 1", ready_in); end
        compared++; if (credit_avail !== 4'b0100) begin mismatched++; $display("[TB] FAIL exhaust_avail_return got %b exp 0100", credit_avail); end
        step();
        valid_in = 1'b0;
        compared++; if (valid_out !== 4'b0100) begin mismatched++; $display("[TB] FAIL exhaust_valid got %b exp 0100", valid_out); end
        compared++; if (data_out !== 32'hC0) begin mismatched++; $display("[TB] FAIL exhaust_data got %h exp c0", data_out); end
        step();
    endtask

    task automatic test_backpressure_hold();
        logic [2:0] otherReady [5];
        otherReady = '{3'b111, 3'b000, 3'b101, 3'b010, 3'b111};
        doReset();
        ready_out = 4'b1110;
        valid_in  = 1'b1;
        data_in   = 32'hD0;
        step();
        data_in = 32'hD1;
        for (int k = 0; k < 5; k++) begin
            ready_out = {otherReady[k], 1'b0};
            #1;
            compared++; if (valid_out !== 4'b0001) begin mismatched++; $display("[TB] FAIL hold_valid%0d got %b exp 0001", k, valid_out); end
            compared++; if (data_out !== 32'hD0) begin mismatched++; $display("[TB] FAIL hold_data%0d got %h exp d0", k, data_out); end
            compared++; if (ready_in !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_ready%0d got %b exp 0", k, ready_in); end
            step();
        end
        ready_out = 4'b1111;
        #1;
        compared++; if (ready_in !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_release_ready got %b exp 1", ready_in); end
        step();
        valid_in = 1'b0;
        compared++; if (valid_out !== 4'b0001) begin mismatched++; $display("[TB] FAIL hold_next_valid got %b exp 0001", valid_out); end
        compared++; if (data_out !== 32'hD1) begin mismatched++; $display("[TB] FAIL hold_next_data got %h exp d1", data_out); end
        step();
        compared++; if (valid_out !== 4'b0000) begin mismatched++; $display("[TB] FAIL hold_drain got %b exp 0000", valid_out); end
    endtask

    task automatic test_consume_return();
        doReset();
        valid_in = 1'b1;
        data_in  = 32'hE0;
        step();
        data_in       = 32'hE1;
        credit_return = 4'b0001;
        step();
        credit_return = 4'b0000;
        compared++; if (lane_index !== 2'd0) begin mismatched++; $display("[TB] FAIL cr_lane1 got %0d exp 0", lane_index); end
        compared++; if (credit_avail !== 4'b1111) begin mismatched++; $display("[TB] FAIL cr_avail1 got %b exp 1111", credit_avail); end
        data_in = 32'hE2;
        step();
        valid_in = 1'b0;
        compared++; if (lane_index !== 2'd0) begin mismatched++; $display("[TB] FAIL cr_lane2 got %0d exp 0", lane_index); end
        compared++; if (data_out !== 32'hE2) begin mismatched++; $display("[TB] FAIL cr_data2 got %h exp e2", data_out); end
        compared++; if (credit_avail !== 4'b1110) begin mismatched++; $display("[TB] FAIL cr_avail2 got %b exp 1110", credit_avail); end
        step();
    endtask

    task automatic test_reset_midflight();
        doReset();
        ready_out = 4'b0000;
        valid_in  = 1'b1;
        data_in   = 32'hF0;
        step();
        valid_in = 1'b0;
        compared++; if (valid_out !== 4'b0001) begin mismatched++; $display("[TB] FAIL mid_full got %b exp 0001", valid_out); end
        #2;
        reset = 1'b0;
        #1;
        compared++; if (valid_out !== 4'b0000) begin mismatched++; $display("[TB] FAIL mid_valid got %b exp 0000", valid_out); end
        compared++; if (data_out !== 32'h0) begin mismatched++; $display("[TB] FAIL mid_data got %h exp 0", data_out); end
        step();
        reset     = 1'b1;
        ready_out = 4'b1111;
        step();
        compared++; if (credit_avail !== 4'b1111) begin mismatched++; $display("[TB] FAIL mid_avail got %b exp 1111", credit_avail); end
        compared++; if (ready_in !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_ready got %b exp 1", ready_in); end
        compared++; if (lane_index !== 2'd0) begin mismatched++; $display("[TB] FAIL mid_lane got %0d exp 0", lane_index); end
    endtask

`ifdef VX_DISPATCH_LOCK_EN
    task automatic test_lock();
        doReset();
        valid_in = 1'b1;
        data_in  = 32'h50;
        step();
        data_in = 32'h51;
        step();
        compared++; if (lane_index !== 2'd0) begin mismatched++; $display("[TB] FAIL lock_lane0 got %0d exp 0", lane_index); end
        compared++; if (ready_in !== 1'b0) begin mismatched++; $display("[TB] FAIL lock_ready0 got %b exp 0", ready_in); end
        valid_in = 1'b0;
        unlock   = 1'b1;
        step();
        unlock = 1'b0;
        compared++; if (ready_in !== 1'b1) begin mismatched++; $display("[TB] FAIL lock_unlocked_ready got %b exp 1", ready_in); end
        valid_in      = 1'b1;
        data_in       = 32'h60;
        credit_return = 4'b0001;
        step();
        compared++; if (lane_index !== 2'd1) begin mismatched++; $display("[TB] FAIL lock_lane1a got %0d exp 1", lane_index); end
        data_in = 32'h61;
        step();
        credit_return = 4'b0000;
        compared++; if (lane_index !== 2'd1) begin mismatched++; $display("[TB] FAIL lock_lane1b got %0d exp 1", lane_index); end
        compared++; if (ready_in !== 1'b0) begin mismatched++; $display("[TB] FAIL lock_ready1 got %b exp 0", ready_in); end
        compared++; if (credit_avail !== 4'b1101) begin mismatched++; $display("[TB] FAIL lock_avail got %b exp 1101", credit_avail); end
        valid_in = 1'b0;
        unlock   = 1'b1;
        step();
        unlock   = 1'b0;
        valid_in = 1'b1;
        data_in  = 32'h70;
        step();
        valid_in = 1'b0;
        compared++; if (lane_index !== 2'd0) begin mismatched++; $display("[TB] FAIL lock_relock got %0d exp 0", lane_index); end
        compared++; if (data_out !== 32'h70) begin mismatched++; $display("[TB] FAIL lock_data got %h exp 70", data_out); end
        step();
    endtask
`endif

    // Runs every scenario in order, then reports the totals.
    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_basic_dispatch();
        test_credit_exhaustion();
        test_backpressure_hold();
        test_consume_return();
        test_reset_midflight();
`ifdef VX_DISPATCH_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
